// File: rtl/arb_pkg.sv
// Shared definitions for the 8-way round-robin arbiter: FSM encoding and
// default sizing used by rr_arb8 and its testbench.
package arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  localparam int ARB_N_REQ    = 8;
  localparam int ARB_ID_W     = 3;
  localparam int ARB_MAX_HOLD = 16;

endpackage

// File: rtl/pri_enc8.sv
// Combinational 8-bit priority encoder: index of the lowest set bit and an
// any-set flag, both forced to zero when the enable is low.
module pri_enc8 (
  input  logic [7:0] vec,
  input  logic       en,
  output logic [2:0] idx,
  output logic       any
);

  // Scanning downward lets the lowest set bit overwrite higher ones.
  always_comb begin
    idx = 3'd0;
    any = 1'b0;
    if (en) begin
      for (int i = 7; i >= 0; i--) begin
        if (vec[i]) begin
          idx = 3'(i);
          any = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/rr_arb8.sv
// Eight-requester round-robin arbiter with a bounded hold time. A holder that
// exceeds MAX_HOLD is revoked and masked until it drops its request.
module rr_arb8
  import arb_pkg::*;
#(
  parameter int N_REQ    = ARB_N_REQ,
  parameter int ID_W     = ARB_ID_W,
  parameter int MAX_HOLD = ARB_MAX_HOLD
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  grant_id,
  output logic             grant_vld,
  output logic             timeout
);

  localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD - 1);

  arb_state_t       state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic             vld_q, vld_d;
  logic             to_q, to_d;
  logic [ID_W-1:0]  ptr_q, ptr_d;
  logic [N_REQ-1:0] mask_q, mask_d;
  logic [7:0]       hold_q, hold_d;

  logic [N_REQ-1:0]   eligible;
  logic [2*N_REQ-1:0] doubled;
  logic [N_REQ-1:0]   rotated;
  logic [2:0]         enc_idx;
  logic               enc_any;
  logic [ID_W-1:0]    winner;

  // Rotating right by ptr puts the pointer position at bit 0, so the lowest
  // set bit of the rotated vector is the next requester in round-robin order.
  assign eligible = req & ~mask_q;
  assign doubled  = {eligible, eligible};
  assign rotated  = doubled[ptr_q +: N_REQ];
  assign winner   = enc_idx + ptr_q;

  pri_enc8 u_pri_enc8 (
    .vec (rotated),
    .en  (en),
    .idx (enc_idx),
    .any (enc_any)
  );

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    id_d    = id_q;
    vld_d   = vld_q;
    to_d    = 1'b0;
    ptr_d   = ptr_q;
    mask_d  = mask_q & req;
    hold_d  = hold_q;
    case (state_q)
      IDLE: begin
        if (enc_any) begin
          state_d = BUSY;
          grant_d = {{(N_REQ-1){1'b0}}, 1'b1} << winner;
          id_d    = winner;
          vld_d   = 1'b1;
          hold_d  = 8'd0;
        end
      end
      BUSY: begin
        if (hold_q != 8'hFF) begin
          hold_d = hold_q + 8'd1;
        end
        // A dropped request wins over the hold limit, so a simultaneous
        // release is never reported as a timeout.
        if (!req[id_q] || (hold_q == HOLD_LIMIT)) begin
          state_d = IDLE;
          grant_d = '0;
          id_d    = '0;
          vld_d   = 1'b0;
          ptr_d   = id_q + 1'b1;
          if (req[id_q]) begin
            to_d         = 1'b1;
            mask_d[id_q] = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      id_q    <= '0;
      vld_q   <= 1'b0;
      to_q    <= 1'b0;
      ptr_q   <= '0;
      mask_q  <= '0;
      hold_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      id_q    <= id_d;
      vld_q   <= vld_d;
      to_q    <= to_d;
      ptr_q   <= ptr_d;
      mask_q  <= mask_d;
      hold_q  <= hold_d;
    end
  end

  assign grant     = grant_q;
  assign grant_id  = id_q;
  assign grant_vld = vld_q;
  assign timeout   = to_q;

endmodule

// File: tb/tb_rr_arb8.sv
// Self-checking bench for rr_arb8: a table of per-cycle vectors plus hand
// sequences for timeout, simultaneous release and asynchronous reset.
module tb_rr_arb8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [7:0] req;
  logic [7:0] grant;
  logic [2:0] grant_id;
  logic       grant_vld;
  logic       timeout;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       r;
    logic       e;
    logic [7:0] q;
    logic [7:0] g;
    logic [2:0] id;
    logic       to;
  } vec_t;

  typedef struct {
    logic [7:0] g;
    logic [2:0] id;
    logic       vld;
    logic       to;
    string      tag;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];

  rr_arb8 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .req       (req),
    .grant     (grant),
    .grant_id  (grant_id),
    .grant_vld (grant_vld),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  task automatic applyStimulus(input logic r, input logic e, input logic [7:0] q,
                               input logic [7:0] g, input logic [2:0] id,
                               input logic to, input string tag);
    exp_t x;
    rst_n = r;
    en    = e;
    req   = q;
    x.g   = g;
    x.id  = id;
    x.vld = |g;
    x.to  = to;
    x.tag = tag;
    sb.push_back(x);
  endtask

  task automatic checkOutput();
    exp_t x;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_empty: no expected entry queued");
      return;
    end
    x = sb.pop_front();
    if ({grant, grant_id, grant_vld, timeout} !== {x.g, x.id, x.vld, x.to}) begin
      errors++;
      $display("[TB] FAIL %s: got grant=%b id=%0d vld=%b to=%b, want grant=%b id=%0d vld=%b to=%b",
               x.tag, grant, grant_id, grant_vld, timeout, x.g, x.id, x.vld, x.to);
    end
  endtask

  task automatic step(input logic r, input logic e, input logic [7:0] q,
                      input logic [7:0] g, input logic [2:0] id,
                      input logic to, input string tag);
    applyStimulus(r, e, q, g, id, to, tag);
    @(posedge clk);
    @(negedge clk);
    checkOutput();
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    req   = 8'h00;

    // Basic grant/release, pointer advance to 1 and wrap from ptr=2.
    tbl.push_back('{1'b0, 1'b0, 8'h00, 8'h00, 3'd0, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 8'h01, 8'h01, 3'd0, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 8'h01, 8'h01, 3'd0, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 8'h00, 8'h00, 3'd0, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 8'h03, 8'h02, 3'd1, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 8'h01, 8'h00, 3'd0, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 8'h01, 8'h01, 3'd0, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 8'h00, 8'h00, 3'd0, 1'b0});
    // Fairness after reset: order 0, 2, 7, 0 with an idle cycle between.
    tbl.push_back('{1'b0, 1'b1, 8'h00, 8'h00, 3'd0, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 8'h85, 8'h01, 3'd0, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 8'h85, 8'h01, 3'd0, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 8'h85, 8'h01, 3'd0, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 8'h84, 8'h00, 3'd0, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 8'h85, 8'h04, 3'd2, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 8'h85, 8'h04, 3'd2, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 8'h85, 8'h04, 3'd2, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 8'h81, 8'h00, 3'd0, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 8'h85, 8'h80, 3'd7, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 8'h85, 8'h80, 3'd7, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 8'h85, 8'h80, 3'd7, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 8'h05, 8'h00, 3'd0, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 8'h85, 8'h01, 3'd0, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 8'h84, 8'h00, 3'd0, 1'b0});
    // Enable gating with ptr=1; en low mid-grant does not cut the grant.
    tbl.push_back('{1'b1, 1'b0, 8'h30, 8'h00, 3'd0, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 8'h30, 8'h00, 3'd0, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 8'h30, 8'h10, 3'd4, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 8'h30, 8'h10, 3'd4, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 8'h30, 8'h10, 3'd4, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 8'h20, 8'h00, 3'd0, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 8'h20, 8'h00, 3'd0, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 8'h20, 8'h20, 3'd5, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 8'h00, 8'h00, 3'd0, 1'b0});
    // Wrap-around: release from 6 leaves ptr=7, then 0 wins, then ptr=1.
    tbl.push_back('{1'b1, 1'b1, 8'h40, 8'h40, 3'd6, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 8'h00, 8'h00, 3'd0, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 8'h03, 8'h01, 3'd0, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 8'h00, 8'h00, 3'd0, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 8'h03, 8'h02, 3'd1, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 8'h00, 8'h00, 3'd0, 1'b0});

    @(negedge clk);
    foreach (tbl[i]) begin
      step(tbl[i].r, tbl[i].e, tbl[i].q, tbl[i].g, tbl[i].id, tbl[i].to,
           $sformatf("vec%0d", i));
    end

    // Hold limit: 16 grant cycles, one timeout pulse, then masked.
    for (int i = 1; i <= 20; i++) begin
      step(1'b1, 1'b1, 8'h08, (i <= 16) ? 8'h08 : 8'h00, (i <= 16) ? 3'd3 : 3'd0,
           (i == 17), $sformatf("timeout_c%0d", i));
    end
    step(1'b1, 1'b1, 8'h00, 8'h00, 3'd0, 1'b0, "mask_clear");
    step(1'b1, 1'b1, 8'h08, 8'h08, 3'd3, 1'b0, "regrant_after_mask");
    step(1'b1, 1'b1, 8'h00, 8'h00, 3'd0, 1'b0, "regrant_release");

    // Request drops on the very cycle the limit is hit: plain release.
    for (int i = 1; i <= 16; i++) begin
      step(1'b1, 1'b1, 8'h08, 8'h08, 3'd3, 1'b0, $sformatf("simul_c%0d", i));
    end
    step(1'b1, 1'b1, 8'h00, 8'h00, 3'd0, 1'b0, "simul_release");
    step(1'b1, 1'b1, 8'h08, 8'h08, 3'd3, 1'b0, "simul_not_masked");
    step(1'b1, 1'b1, 8'h00, 8'h00, 3'd0, 1'b0, "simul_end");

    // Asynchronous reset between edges while requester 6 holds the grant.
    step(1'b1, 1'b1, 8'h40, 8'h40, 3'd6, 1'b0, "pre_reset_grant");
    #2;
    applyStimulus(1'b0, 1'b1, 8'h40, 8'h00, 3'd0, 1'b0, "async_reset");
    #1;
    checkOutput();
    @(negedge clk);
    step(1'b1, 1'b1, 8'h41, 8'h01, 3'd0, 1'b0, "post_reset_ptr0");
    step(1'b1, 1'b1, 8'h00, 8'h00, 3'd0, 1'b0, "final_release");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rr_arb8.md
RR_ARB8 -- requirements
Module: rr_arb8

Interface
REQ-001 The module SHALL have parameter N_REQ, default 8, giving the number of requesters; only the value 8 is supported.
REQ-002 The module SHALL have parameter ID_W, default 3, giving the width of the grant index.
REQ-003 The module SHALL have parameter MAX_HOLD, default 16, giving the maximum number of cycles a grant is held; the legal range is 2 to 255.
REQ-004 clk  input  1  Single clock; all state changes on the rising edge.
REQ-005 rst_n  input  1  Reset, asynchronous and active-low.
REQ-006 en  input  1  Arbitration enable; when low, no new grant is issued.
REQ-007 req  input  8  Per-requester request, level-sensitive, held for as long as the resource is wanted.
REQ-008 grant  output  8  Registered one-hot grant; all zero when idle.
REQ-009 grant_id  output  3  Registered binary index of the granted requester; 0 when idle.
REQ-010 grant_vld  output  1  High while any grant is asserted.
REQ-011 timeout  output  1  One-cycle pulse when a grant is revoked because MAX_HOLD was reached.

Function
REQ-012 The FSM SHALL have exactly two states: IDLE and BUSY.
REQ-013 IDLE to BUSY transition: en=1 and at least one unmasked req bit set. Grant appears on the first clock edge after the request is sampled (latency 1).
REQ-014 Winner selection: first set bit of (req & ~mask), searching upward from pointer ptr with wrap 7 to 0.
REQ-015 BUSY to IDLE transition: on the edge where req[grant_id]=0 is sampled, or when the hold counter reaches MAX_HOLD-1, whichever comes first. grant, grant_vld and grant_id clear on that edge.
REQ-016 On every BUSY to IDLE transition, ptr SHALL load (grant_id+1) mod 8, giving round-robin fairness.
REQ-017 The FSM SHALL spend at least one cycle in IDLE between consecutive grants; there is no back-to-back handoff.
REQ-018 Hold counter (8-bit): clears on entry to BUSY, increments every BUSY cycle, saturates and never wraps.
REQ-019 On a timeout exit: timeout=1 for exactly that one cycle, and mask[grant_id] sets.
REQ-020 mask[i] SHALL clear on the first cycle in which req[i]=0 is sampled; a masked requester is never granted.
REQ-021 If en falls during BUSY, the current grant SHALL complete normally; en is only examined in IDLE.
REQ-022 If requests appear in IDLE while en=0, no grant is issued and ptr does not change.
REQ-023 If all set requests are masked, the FSM SHALL stay in IDLE with outputs all zero.
REQ-024 Requests other than the granted one SHALL have no effect during BUSY.
REQ-025 When the granted request drops and the timeout limit is reached in the same cycle, the exit SHALL be treated as a normal release: no timeout pulse and no mask set.
REQ-026 grant SHALL always be one-hot or zero, and grant_vld SHALL equal the OR-reduction of grant.

Reset
REQ-027 While rst_n=0, asynchronously: state=IDLE; grant=0, grant_id=0, grant_vld=0, timeout=0; ptr=0; mask=0; hold counter=0.
REQ-028 Reset asserted mid-grant SHALL drop the grant immediately, without waiting for a clock.
REQ-029 After rst_n deasserts, the first grant may be issued on the first rising edge that samples a valid request.

Structure
REQ-030 The state encoding (IDLE, BUSY), N_REQ, ID_W and the default for MAX_HOLD SHALL live in the shared package arb_pkg.
REQ-031 Winner search SHALL use one sub-module, pri_enc8. It is combinational: 8-bit input, enable input, 3-bit lowest-set-bit index, and an any-set flag.
REQ-032 rr_arb8 SHALL rotate (req & ~mask) right by ptr, feed the result to pri_enc8, and add ptr mod 8 to the returned index to get the winner.
REQ-033 All outputs SHALL be driven directly from flops, with no combinational path from req to grant.

Verification
REQ-034 After reset, en=1, req=8'b00000001 -> grant=8'b00000001 and grant_id=0 one cycle later; req=0 -> grant=0 the next cycle and ptr=1.
REQ-035 Fairness: req=8'b10000101 held constant, each grant released after 3 cycles -> grant order 0, 2, 7, 0, with one idle cycle between each grant.
REQ-036 Timeout: req=8'b00001000 held for 20 cycles -> grant lasts exactly 16 cycles, then timeout pulses once and no regrant to requester 3 until req[3] drops and rises again.
REQ-037 Enable gating: en=0, req=8'b00110000 -> no grant; en=1 -> grant=8'b00010000 one cycle later; en dropped mid-grant -> grant persists until req[4]=0.
REQ-038 Reset mid-grant: grant=8'b01000000 active, rst_n pulsed low between clock edges -> outputs zero immediately; after release, req=8'b01000001 -> grant_id=0, since ptr was reset to 0.
REQ-039 Wrap-around: ptr=7 after a release from requester 6, req=8'b00000011 -> grant_id=0, then ptr=1.
